// File: rtl/lane_capture_sched.sv
// Round-robin capture of one sample per lane per frame, then a 1-cycle commit to the latch stage.
// Latency: one capture per COLLECT cycle, commit the cycle after the last capture or the timeout; no backpressure.
module lane_capture_sched #(
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 1000,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       req,
    input  logic [DW-1:0]    din0,
    input  logic [DW-1:0]    din1,
    input  logic [DW-1:0]    din2,
    input  logic [DW-1:0]    din3,
    output logic [3:0]       gnt,
    output logic [DW-1:0]    cap0,
    output logic [DW-1:0]    cap1,
    output logic [DW-1:0]    cap2,
    output logic [DW-1:0]    cap3,
    output logic             commit,
    output logic             busy,
    output logic [3:0]       missing,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_rr_ptr;
    logic [3:0]        r_captured;
    logic [TW-1:0]     r_timer;
    logic [3:0]        r_gnt;
    logic [DW-1:0]     r_cap [4];
    logic              r_commit;
    logic              r_busy;
    logic [3:0]        r_missing;
    logic [CNT_W-1:0]  r_frame_cnt;

    logic [DW-1:0]     w_din [4];
    logic [3:0]        w_elig;
    logic              w_pick_vld;
    logic [1:0]        w_pick_idx;
    logic [3:0]        w_pick_oh;
    logic              w_cap_now;
    logic [3:0]        w_captured_nxt;
    logic              w_full;
    logic              w_tmo;

    assign w_din[0] = din0;
    assign w_din[1] = din1;
    assign w_din[2] = din2;
    assign w_din[3] = din3;

    assign w_elig = req & ~r_captured;

    // Scan downwards so the lane closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        logic [1:0] v_idx;
        w_pick_vld = 1'b0;
        w_pick_idx = 2'd0;
        v_idx      = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            v_idx = r_rr_ptr + 2'(i);
            if (w_elig[v_idx]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = v_idx;
            end
        end
    end

    assign w_pick_oh      = 4'b0001 << w_pick_idx;
    assign w_cap_now      = (r_state == COLLECT) && !abort && w_pick_vld;
    assign w_captured_nxt = r_captured | (w_cap_now ? w_pick_oh : 4'b0000);
    assign w_full         = (w_captured_nxt == 4'hF);
    assign w_tmo          = (r_timer == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = COLLECT;
            COLLECT: begin
                if (abort)               w_state_nxt = IDLE;
                else if (w_full || w_tmo) w_state_nxt = COMMIT;
            end
            COMMIT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr    <= 2'd0;
            r_captured  <= 4'd0;
            r_timer     <= '0;
            r_gnt       <= 4'd0;
            r_commit    <= 1'b0;
            r_busy      <= 1'b0;
            r_missing   <= 4'd0;
            r_frame_cnt <= '0;
            for (int i = 0; i < 4; i++) r_cap[i] <= '0;
        end else begin
            r_gnt    <= w_cap_now ? w_pick_oh : 4'b0000;
            r_commit <= (w_state_nxt == COMMIT);
            r_busy   <= (w_state_nxt != IDLE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_captured <= 4'd0;
                        r_timer    <= '0;
                    end
                end
                COLLECT: begin
                    r_timer <= r_timer + 1'b1;
                    if (w_cap_now) begin
                        r_cap[w_pick_idx] <= w_din[w_pick_idx];
                        r_captured        <= w_captured_nxt;
                        r_rr_ptr          <= w_pick_idx + 2'd1;
                    end
                    // A full frame yields ~4'hF = 0, so one expression covers both commit causes.
                    if (w_state_nxt == COMMIT) r_missing <= ~w_captured_nxt;
                end
                COMMIT: begin
                    if (r_frame_cnt != {CNT_W{1'b1}}) r_frame_cnt <= r_frame_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign cap0      = r_cap[0];
    assign cap1      = r_cap[1];
    assign cap2      = r_cap[2];
    assign cap3      = r_cap[3];
    assign commit    = r_commit;
    assign busy      = r_busy;
    assign missing   = r_missing;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_lane_capture_sched.sv
// Bench for lane_capture_sched: frame-level reference model predicting grant order, commit timing and staged data.
module tb_lane_capture_sched;

    localparam int DW  = 32;
    localparam int TMO = 16;
    localparam int CW  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           abort;
    logic [3:0]     req;
    logic [DW-1:0]  tdin [4];
    logic [3:0]     gnt;
    logic [DW-1:0]  cap0, cap1, cap2, cap3;
    logic           commit;
    logic           busy;
    logic [3:0]     missing;
    logic [CW-1:0]  frame_cnt;

    lane_capture_sched #(.DW(DW), .TIMEOUT_CYC(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .req(req),
        .din0(tdin[0]), .din1(tdin[1]), .din2(tdin[2]), .din3(tdin[3]),
        .gnt(gnt), .cap0(cap0), .cap1(cap1), .cap2(cap2), .cap3(cap3),
        .commit(commit), .busy(busy), .missing(missing), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: pointer to the lane with first claim, staged data, last-frame results.
    int            m_ptr;
    logic [DW-1:0] m_cap [4];
    logic [3:0]    m_missing;
    int            m_fcnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr     = 0;
        m_missing = 4'd0;
        m_fcnt    = 0;
        for (int i = 0; i < 4; i++) m_cap[i] = '0;
    endtask

    task automatic check_results(input string tag);
        check({tag, "_cap0"}, cap0, m_cap[0]);
        check({tag, "_cap1"}, cap1, m_cap[1]);
        check({tag, "_cap2"}, cap2, m_cap[2]);
        check({tag, "_cap3"}, cap3, m_cap[3]);
        check({tag, "_missing"}, missing, m_missing);
        check({tag, "_frame_cnt"}, frame_cnt, m_fcnt);
    endtask

    // Called at a negedge. req and data are held for the whole frame; ab = edge index carrying abort (0 = none).
    task automatic run_frame(input logic [3:0] rq, input int ab, input logic [DW-1:0] dv [4]);
        int   order[$];
        int   n;
        int   end_edge;
        logic [3:0] exp_gnt;
        for (int i = 0; i < 4; i++) if (rq[(m_ptr + i) % 4]) order.push_back((m_ptr + i) % 4);
        n        = order.size();
        end_edge = (n == 4) ? 4 : TMO;
        req   = rq;
        start = 1'b1;
        for (int i = 0; i < 4; i++) tdin[i] = dv[i];
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("busy_rise", busy, 1'b1);
        for (int c = 1; c <= end_edge; c++) begin
            if (c == ab) abort = 1'b1;
            @(posedge clk);
            @(negedge clk);
            abort = 1'b0;
            if (c == ab) begin
                check("abort_gnt", gnt, 4'd0);
                check("abort_commit", commit, 1'b0);
                check("abort_busy", busy, 1'b0);
                check_results("abort");
                req = 4'd0;
                return;
            end
            exp_gnt = 4'd0;
            if (c <= n) begin
                exp_gnt            = 4'b0001 << order[c-1];
                m_cap[order[c-1]]  = dv[order[c-1]];
                m_ptr              = (order[c-1] + 1) % 4;
            end
            check("gnt", gnt, exp_gnt);
            check("commit", commit, c == end_edge);
            check("busy", busy, 1'b1);
        end
        m_missing = ~rq;
        check("missing_at_commit", missing, m_missing);
        @(posedge clk);
        @(negedge clk);
        if (m_fcnt < (1 << CW) - 1) m_fcnt++;
        check("commit_fall", commit, 1'b0);
        check("busy_fall", busy, 1'b0);
        check("gnt_idle", gnt, 4'd0);
        check_results("frame");
        req = 4'd0;
    endtask

    initial begin
        logic [DW-1:0] dv [4];
        logic [DW-1:0] dfix [4];
        for (int i = 0; i < 4; i++) dfix[i] = 32'hA0 + 32'(i);

        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        req   = 4'd0;
        for (int i = 0; i < 4; i++) tdin[i] = '0;
        model_reset();
        #12;
        check("rst_gnt", gnt, 4'd0);
        check("rst_commit", commit, 1'b0);
        check("rst_busy", busy, 1'b0);
        check_results("rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // All lanes requesting, pointer at 0.
        run_frame(4'hF, 0, dfix);
        // Single lane, ends on timeout.
        for (int i = 0; i < 4; i++) dv[i] = $urandom;
        run_frame(4'b0100, 0, dv);
        // Timeout frame leaves pointer at 2, so lane 3 precedes lane 0 next.
        for (int i = 0; i < 4; i++) dv[i] = $urandom;
        run_frame(4'b0011, 0, dv);
        check("ptr_after_0011", m_ptr, 2);
        for (int i = 0; i < 4; i++) dv[i] = $urandom;
        run_frame(4'b1001, 0, dv);
        // Abort after two captures, then a normal full frame.
        for (int i = 0; i < 4; i++) dv[i] = $urandom;
        run_frame(4'hF, 3, dv);
        for (int i = 0; i < 4; i++) dv[i] = $urandom;
        run_frame(4'hF, 0, dv);

        for (int f = 0; f < 40; f++) begin
            int ab;
            ab = 0;
            if ($urandom_range(3) == 0) ab = $urandom_range(TMO, 1);
            for (int i = 0; i < 4; i++) dv[i] = $urandom;
            run_frame(4'($urandom_range(15)), ab, dv);
            repeat ($urandom_range(2)) begin
                @(negedge clk);
                check("idle_busy", busy, 1'b0);
            end
        end

        // Saturation of the frame counter.
        for (int f = 0; f < 260; f++) begin
            for (int i = 0; i < 4; i++) dv[i] = $urandom;
            run_frame(4'hF, 0, dv);
        end
        check("frame_cnt_sat", frame_cnt, 8'hFF);

        // Asynchronous reset in the middle of a frame.
        req   = 4'b0001;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("arst_gnt", gnt, 4'd0);
        check("arst_commit", commit, 1'b0);
        check("arst_busy", busy, 1'b0);
        check_results("arst");
        req = 4'd0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_frame(4'hF, 0, dfix);
        check("post_rst_frame_cnt", frame_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
